// File: rtl/ram_pkg.sv
// Shared types and constants for the frame-capture buffer.
// The parity helper is only referenced when RAM_PARITY_EN is defined.
package ram_pkg;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Even parity bit: makes the total count of ones, parity bit included, even.
    function automatic logic even_par(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_store.sv
// Single-clock storage array: synchronous write port, asynchronous read port.
module ram_store
    import ram_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ram_frame_capture.sv
// Captures one address-aligned 32-word frame, then drains it over valid/ready.
// Optional feature macro: RAM_PARITY_EN (stores and checks a per-word even parity bit).
module ram_frame_capture
    import ram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              frame_done,
    output logic              sync_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [5:0]        rd_count,
    output logic              par_err
);

`ifdef RAM_PARITY_EN
    localparam int SW = DATA_W + 1;
`else
    localparam int SW = DATA_W;
`endif

    state_t            state_r;
    logic [ADDR_W-1:0] exp_addr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic              we_s;
    logic              load_s;
    logic              hs_s;
    logic [SW-1:0]     wdata_s;
    logic [SW-1:0]     rdata_s;

`ifdef RAM_PARITY_EN
    assign wdata_s = {even_par(64'(din)), din};
`else
    assign wdata_s = din;
`endif

    assign hs_s = dout_valid && dout_ready;
    assign busy = (state_r != IDLE);

    // Write enable for the capture path and dout reload strobe for the drain path.
    always_comb begin
        we_s   = 1'b0;
        load_s = 1'b0;
        case (state_r)
            ARM: begin
                we_s = (addr_in == 5'd0);
            end
            CAPTURE: begin
                we_s   = (addr_in == exp_addr_r);
                load_s = we_s && (addr_in == 5'd31);
            end
            DRAIN: begin
                load_s = hs_s && (rd_count != 6'd31);
            end
            default: begin
                we_s   = 1'b0;
                load_s = 1'b0;
            end
        endcase
    end

    ram_store #(.W(SW)) u_store (
        .clk   (clk),
        .we    (we_s),
        .waddr (addr_in),
        .wdata (wdata_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Capture/drain sequencer with registered status and stream outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r    <= IDLE;
            exp_addr_r <= 5'd0;
            rd_ptr_r   <= 5'd0;
            rd_count   <= 6'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (load_s) begin
                dout     <= rdata_s[DATA_W-1:0];
                rd_ptr_r <= rd_ptr_r + 5'd1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= ARM;
                        rd_count <= 6'd0;
                        rd_ptr_r <= 5'd0;
                    end
                end
                ARM: begin
                    if (we_s) begin
                        exp_addr_r <= 5'd1;
                        state_r    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (we_s) begin
                        exp_addr_r <= exp_addr_r + 5'd1;
                        if (load_s) begin
                            state_r    <= DRAIN;
                            frame_done <= 1'b1;
                            dout_valid <= 1'b1;
                        end
                    end else begin
                        sync_err <= 1'b1;
                        state_r  <= ARM;
                    end
                end
                DRAIN: begin
                    if (hs_s) begin
                        rd_count <= rd_count + 6'd1;
                        if (rd_count == 6'd31) begin
                            dout_valid <= 1'b0;
                            state_r    <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_PARITY_EN
    logic dout_par_r;

    // Track the stored parity of the presented word; flag (sticky) on mismatch at handshake.
    always_ff @(posedge clk) begin
        if (res) begin
            dout_par_r <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            if (load_s) begin
                dout_par_r <= rdata_s[DATA_W];
            end
            if (state_r == IDLE && start) begin
                par_err <= 1'b0;
            end else if (state_r == DRAIN && hs_s && (even_par(64'(dout)) != dout_par_r)) begin
                par_err <= 1'b1;
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule
